// File: rtl/writeback_stage.sv
// +--------------------------------------------------------------------------+
// | writeback_stage : MEM/WB register, writeback mux, load align/extend and  |
// | retire strobe. Define RETIRE_COUNT_EN to add the o_instret counter.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             i_clock,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_reg_we,
  input  logic [4:0]       i_rd,
  input  logic [1:0]       i_wb_sel,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_load_data,
  input  logic [2:0]       i_funct3,
  output logic             o_write_cs,
  output logic [4:0]       o_rd,
  output logic [XLEN-1:0]  o_regdat,
  output logic             o_misaligned,
  output logic             o_retire
`ifdef RETIRE_COUNT_EN
  ,
  output logic [CNT_W-1:0] o_instret
`endif
);

  localparam logic [1:0] c_sel_alu  = 2'b00;
  localparam logic [1:0] c_sel_load = 2'b01;
  localparam logic [1:0] c_sel_link = 2'b10;

  localparam logic [2:0] c_lb  = 3'b000;
  localparam logic [2:0] c_lh  = 3'b001;
  localparam logic [2:0] c_lw  = 3'b010;
  localparam logic [2:0] c_lbu = 3'b100;
  localparam logic [2:0] c_lhu = 3'b101;

  logic            w_take;
  logic [1:0]      w_addr_lo;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic            w_load_err;
  logic            w_err;
  logic [XLEN-1:0] w_load_val;
  logic [XLEN-1:0] w_sel_val;

  logic            write_cs_d, write_cs_q;
  logic [4:0]      rd_d, rd_q;
  logic [XLEN-1:0] regdat_d, regdat_q;
  logic            misaligned_d, misaligned_q;
  logic            retire_d, retire_q;

  always_comb begin
    w_take     = i_valid & ~i_stall;
    w_addr_lo  = i_alu_result[1:0];
    w_byte     = 8'(i_load_data >> {w_addr_lo, 3'b000});
    w_half     = w_addr_lo[1] ? i_load_data[31:16] : i_load_data[15:0];
    w_load_err = 1'b0;
    w_load_val = '0;
    case (i_funct3)
      c_lb:  w_load_val = {{24{w_byte[7]}}, w_byte};
      c_lbu: w_load_val = {24'd0, w_byte};
      c_lh: begin
        w_load_val = {{16{w_half[15]}}, w_half};
        w_load_err = w_addr_lo[0];
      end
      c_lhu: begin
        w_load_val = {16'd0, w_half};
        w_load_err = w_addr_lo[0];
      end
      c_lw: begin
        w_load_val = i_load_data;
        w_load_err = (w_addr_lo != 2'b00);
      end
      default: w_load_err = 1'b1;
    endcase

    w_err = (i_wb_sel == c_sel_load) & w_load_err;

    case (i_wb_sel)
      c_sel_alu:  w_sel_val = i_alu_result;
      c_sel_load: w_sel_val = w_load_val;
      c_sel_link: w_sel_val = i_pc + XLEN'(4);
      default:    w_sel_val = '0;
    endcase

    // A bubble only clears the strobes; index and data keep their last value.
    write_cs_d   = w_take & i_reg_we & (i_rd != 5'd0) & ~w_err;
    misaligned_d = w_take & w_err;
    retire_d     = w_take & ~w_err;
    rd_d         = w_take ? i_rd : rd_q;
    regdat_d     = w_take ? (w_err ? '0 : w_sel_val) : regdat_q;
  end

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      write_cs_q   <= 1'b0;
      rd_q         <= '0;
      regdat_q     <= '0;
      misaligned_q <= 1'b0;
      retire_q     <= 1'b0;
    end else begin
      write_cs_q   <= write_cs_d;
      rd_q         <= rd_d;
      regdat_q     <= regdat_d;
      misaligned_q <= misaligned_d;
      retire_q     <= retire_d;
    end
  end

  assign o_write_cs   = write_cs_q;
  assign o_rd         = rd_q;
  assign o_regdat     = regdat_q;
  assign o_misaligned = misaligned_q;
  assign o_retire     = retire_q;

`ifdef RETIRE_COUNT_EN
  logic [CNT_W-1:0] instret_d, instret_q;

  // Counts the retire pulse already on the output, so it trails o_retire by one edge.
  always_comb begin
    instret_d = instret_q + CNT_W'(retire_q);
  end

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign o_instret = instret_q;
`endif

endmodule

`default_nettype wire
